// File: rtl/mesi_bus_arbiter.sv
// mesi_bus_arbiter
//
// Shares the single snooping coherence bus between three L1 controllers.
// A round-robin arbiter picks one requester, the transaction is broadcast
// for one cycle, the other caches' snoop responses are collected, then
// either a dirty-line flush, a memory read/write, or nothing (invalidate)
// is sequenced before a one-cycle completion pulse to the requester.
//
// Ports:
//   clock        single rising-edge clock
//   reset        synchronous, active-high
//   req[2:0]     per-cache bus request, held until that cache's done
//   req_op[5:0]  2 bits per cache: 00 read miss, 01 write miss,
//                10 invalidate (S->M upgrade), 11 writeback
//   req_addr     ADDR_W bits per cache
//   gnt[2:0]     one-hot grant, held from BUS through DONE, zero in IDLE
//   bus_valid    one-cycle broadcast strobe
//   bus_op/bus_addr/bus_src  granted transaction, held like gnt
//   snoop_hit    per-cache line present (S/E/M), sampled in SNOOP
//   snoop_dirty  per-cache line in M, sampled in SNOOP
//   mem_req      memory access request, held until mem_ack
//   mem_we       1 = write (flush / writeback), 0 = read
//   mem_ack      single-cycle memory completion
//   done[2:0]    one-cycle completion pulse to the granted cache
//   shared       valid with done: another cache hit on a read miss
//
// All outputs are registered.

module mesi_bus_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [5:0]            req_op,
    input  logic [3*ADDR_W-1:0]   req_addr,
    output logic [2:0]            gnt,
    output logic                  bus_valid,
    output logic [1:0]            bus_op,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [1:0]            bus_src,
    input  logic [2:0]            snoop_hit,
    input  logic [2:0]            snoop_dirty,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic                  mem_ack,
    output logic [2:0]            done,
    output logic                  shared
);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_INV = 2'b10;
    localparam logic [1:0] OP_WB  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUS,
        S_SNOOP,
        S_FLUSH,
        S_MEM,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic [1:0]          last_reg;
    logic [2:0]          gnt_reg;
    logic                bus_valid_reg;
    logic [1:0]          bus_op_reg;
    logic [ADDR_W-1:0]   bus_addr_reg;
    logic [1:0]          bus_src_reg;
    logic                mem_req_reg;
    logic                mem_we_reg;
    logic [2:0]          done_reg;
    logic                shared_reg;
    logic                hit_any_reg;

    // cand[k] is the cache examined k-th in the round-robin search,
    // i.e. (last + 1 + k) mod 3.
    logic [2:0][1:0]     cand;
    // Snoop responses from the source itself are meaningless and masked off.
    logic [2:0]          snoop_mask;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rr
            logic [2:0] sum;
            assign sum        = {1'b0, last_reg} + 3'(gi + 1);
            assign cand[gi]   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            assign snoop_mask[gi] = (bus_src_reg != 2'(gi));
        end
    endgenerate

    logic [1:0] win_idx;
    logic       hit_others;
    logic       dirty_others;

    always_comb begin
        win_idx = cand[2];
        if (req[cand[1]]) win_idx = cand[1];
        if (req[cand[0]]) win_idx = cand[0];
    end

    assign hit_others   = |(snoop_hit   & snoop_mask);
    assign dirty_others = |(snoop_dirty & snoop_mask);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            last_reg      <= 2'd2;
            gnt_reg       <= '0;
            bus_valid_reg <= 1'b0;
            bus_op_reg    <= '0;
            bus_addr_reg  <= '0;
            bus_src_reg   <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            done_reg      <= '0;
            shared_reg    <= 1'b0;
            hit_any_reg   <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            bus_valid_reg <= 1'b0;
            done_reg      <= '0;
            shared_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (|req) begin
                        state_reg     <= S_BUS;
                        last_reg      <= win_idx;
                        gnt_reg       <= 3'b001 << win_idx;
                        bus_valid_reg <= 1'b1;
                        bus_op_reg    <= req_op[{win_idx, 1'b0} +: 2];
                        bus_addr_reg  <= req_addr[ADDR_W*win_idx +: ADDR_W];
                        bus_src_reg   <= win_idx;
                    end
                end
                S_BUS: begin
                    state_reg <= S_SNOOP;
                end
                S_SNOOP: begin
                    // The flush/memory decision uses the live masked
                    // responses; only hit_any is needed later for shared.
                    hit_any_reg <= hit_others;
                    case (bus_op_reg)
                        OP_WB: begin
                            state_reg   <= S_MEM;
                            mem_req_reg <= 1'b1;
                            mem_we_reg  <= 1'b1;
                        end
                        OP_INV: begin
                            state_reg <= S_DONE;
                            done_reg  <= gnt_reg;
                        end
                        default: begin
                            // A dirty owner supplies the line while it is
                            // written back; no separate memory read follows.
                            state_reg   <= dirty_others ? S_FLUSH : S_MEM;
                            mem_req_reg <= 1'b1;
                            mem_we_reg  <= dirty_others;
                        end
                    endcase
                end
                S_FLUSH, S_MEM: begin
                    if (mem_ack) begin
                        state_reg   <= S_DONE;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        done_reg    <= gnt_reg;
                        shared_reg  <= hit_any_reg && (bus_op_reg == OP_RD);
                    end
                end
                S_DONE: begin
                    state_reg    <= S_IDLE;
                    gnt_reg      <= '0;
                    bus_op_reg   <= '0;
                    bus_addr_reg <= '0;
                    bus_src_reg  <= '0;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign bus_valid = bus_valid_reg;
    assign bus_op    = bus_op_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_src   = bus_src_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign done      = done_reg;
    assign shared    = shared_reg;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Testbench for mesi_bus_arbiter: a stimulus process issues batches of
// simultaneous requests and pushes the expected transactions (in
// round-robin order) into a queue; a monitor pops and checks them as
// the DUT broadcasts and completes them.

module tb_mesi_bus_arbiter;

    localparam int AW = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [2:0]      req = '0;
    logic [5:0]      req_op = '0;
    logic [3*AW-1:0] req_addr = '0;
    logic [2:0]      gnt;
    logic            bus_valid;
    logic [1:0]      bus_op;
    logic [AW-1:0]   bus_addr;
    logic [1:0]      bus_src;
    logic [2:0]      snoop_hit = '0;
    logic [2:0]      snoop_dirty = '0;
    logic            mem_req;
    logic            mem_we;
    logic            mem_ack = 1'b0;
    logic [2:0]      done;
    logic            shared;

    always #5 clock = ~clock;

    mesi_bus_arbiter #(.ADDR_W(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .bus_valid   (bus_valid),
        .bus_op      (bus_op),
        .bus_addr    (bus_addr),
        .bus_src     (bus_src),
        .snoop_hit   (snoop_hit),
        .snoop_dirty (snoop_dirty),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .done        (done),
        .shared      (shared)
    );

    typedef struct {
        int            src;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic          shr;
        logic          mem_used;
        logic          we;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] snp_hit_tab[3];
    logic [2:0] snp_dirty_tab[3];
    int         model_last = 2;
    bit         mem_hold = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    int         cycle = 0;

    always @(posedge clock) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Snoopers answer for the broadcast source with the pattern chosen by
    // the stimulus; the values stay put through the SNOOP cycle.
    always @(posedge clock) begin
        #1;
        if (bus_valid && bus_src < 2'd3) begin
            snoop_hit   = snp_hit_tab[bus_src];
            snoop_dirty = snp_dirty_tab[bus_src];
        end
    end

    // Memory model: random 0..3 cycle latency, single-cycle ack, and
    // occasional stray acks while no access is pending.
    int wait_cnt = 0;
    always @(posedge clock) begin
        #1;
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && !mem_hold) begin
            if (wait_cnt == 0) begin
                mem_ack  = 1'b1;
                wait_cnt = $urandom_range(0, 3);
            end else begin
                wait_cnt--;
            end
        end else if (!mem_req && $urandom_range(0, 5) == 0) begin
            mem_ack = 1'b1;
        end
    end

    // Monitor / scoreboard.
    bit   in_flight = 1'b0;
    exp_t cur;
    int   bus_cyc = 0;
    int   ack_cyc = 0;
    int   windows = 0;
    logic prev_mem_req = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            in_flight    = 1'b0;
            prev_mem_req = 1'b0;
        end else begin
            if (bus_valid) begin
                check("bus_valid_while_busy", {31'b0, in_flight}, 0);
                check("bus_expected", {31'b0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    cur       = exp_q.pop_front();
                    in_flight = 1'b1;
                    bus_cyc   = cycle;
                    ack_cyc   = -100;
                    windows   = 0;
                end
            end
            if (in_flight) begin
                check("gnt",      gnt,      32'(1) << cur.src);
                check("bus_src",  bus_src,  cur.src);
                check("bus_op",   bus_op,   cur.op);
                check("bus_addr", bus_addr, cur.addr);
                if (mem_req && !prev_mem_req) windows++;
                if (mem_req) check("mem_we", mem_we, cur.we);
                if (mem_req && mem_ack) ack_cyc = cycle;
                if (done != 3'b000) begin
                    check("done",        done,    32'(1) << cur.src);
                    check("shared",      shared,  cur.shr);
                    check("mem_windows", windows, cur.mem_used ? 1 : 0);
                    if (cur.mem_used)
                        check("done_after_ack", cycle - ack_cyc, 1);
                    else
                        check("inv_latency", cycle - bus_cyc, 2);
                    $display("txn src=%0d op=%0d addr=%0h done=%b shared=%b", cur.src, cur.op, cur.addr, done, shared);
                    in_flight = 1'b0;
                end
            end else if (!bus_valid) begin
                check("idle_outputs", {gnt, bus_op, bus_addr, bus_src, mem_req, mem_we, done, shared}, 0);
            end
            prev_mem_req = mem_req;
        end
    end

    // Reference model: order of service for a batch of simultaneous
    // requests, and the outcome of each transaction from the snoop rules.
    task automatic push_expected(input logic [2:0] mask, input logic [5:0] ops,
                                 input logic [3*AW-1:0] addrs,
                                 input logic [8:0] hits, input logic [8:0] dirts);
        logic [2:0] rem;
        rem = mask;
        while (rem != 3'b000) begin
            int   c;
            exp_t e;
            logic [2:0] others;
            logic hit_o, dirty_o;
            c = 0;
            for (int off = 1; off <= 3; off++) begin
                if (rem[(model_last + off) % 3]) begin
                    c = (model_last + off) % 3;
                    break;
                end
            end
            others    = 3'b111 & ~(3'b001 << c);
            hit_o     = |(hits[3*c +: 3] & others);
            dirty_o   = |(dirts[3*c +: 3] & others);
            e.src      = c;
            e.op       = ops[2*c +: 2];
            e.addr     = addrs[AW*c +: AW];
            e.shr      = hit_o && (e.op == 2'd0);
            e.mem_used = (e.op != 2'd2);
            e.we       = (e.op == 2'd3) || (e.op < 2'd2 && dirty_o);
            exp_q.push_back(e);
            rem[c]     = 1'b0;
            model_last = c;
        end
    endtask

    task automatic run_batch(input logic [2:0] mask, input logic [5:0] ops,
                             input logic [3*AW-1:0] addrs,
                             input logic [8:0] hits, input logic [8:0] dirts);
        for (int i = 0; i < 3; i++) begin
            snp_hit_tab[i]   = hits[3*i +: 3];
            snp_dirty_tab[i] = dirts[3*i +: 3];
        end
        req_op   = ops;
        req_addr = addrs;
        push_expected(mask, ops, addrs, hits, dirts);
        req = mask;
        for (int n = 0; n < 300 && req != 3'b000; n++) begin
            @(posedge clock);
            #1;
            req = req & ~done;
        end
        check("batch_complete", req, 0);
        req = '0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(posedge clock);
        #1;
        reset      = 1'b0;
        model_last = 2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Quiet bus after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("reset_quiet", {gnt, bus_valid, bus_op, bus_addr, bus_src, mem_req, mem_we, done, shared}, 0);
        end
        @(posedge clock);
        #1;

        // Three invalidates then cache 0 again: order 0,1,2,0.
        run_batch(3'b111, 6'b10_10_10, {5'h13, 5'h12, 5'h11}, 9'b011_101_110, 9'b0);
        run_batch(3'b001, 6'b10_10_10, {5'h00, 5'h00, 5'h04}, 9'b0, 9'b0);
        // Cache 1 read miss, nobody holds the line.
        run_batch(3'b010, 6'b00_00_00, {5'h00, 5'h0A, 5'h00}, 9'b0, 9'b0);
        // Cache 0 read miss, cache 2 owns it dirty: flush, shared.
        run_batch(3'b001, 6'b00_00_00, {5'h00, 5'h00, 5'h03}, 9'b000_000_110, 9'b000_000_100);
        // Cache 2 writeback with its own dirty bit set: masked off.
        run_batch(3'b100, 6'b11_00_00, {5'h1F, 5'h00, 5'h00}, 9'b100_000_000, 9'b100_000_000);

        // Cache 2 write miss abandoned by reset during MEM.
        mem_hold = 1'b1;
        snp_hit_tab[2]   = 3'b000;
        snp_dirty_tab[2] = 3'b000;
        req_op   = 6'b01_00_00;
        req_addr = {5'h15, 5'h00, 5'h00};
        push_expected(3'b100, req_op, req_addr, 9'b0, 9'b0);
        req = 3'b100;
        for (int n = 0; n < 20 && !mem_req; n++) begin
            @(posedge clock);
            #1;
        end
        check("reset_test_mem_req", mem_req, 1);
        reset = 1'b1;
        req   = '0;
        @(posedge clock);
        #1;
        reset      = 1'b0;
        model_last = 2;
        mem_hold   = 1'b0;
        @(negedge clock);
        check("mid_reset_outputs", {gnt, bus_valid, bus_op, bus_addr, bus_src, mem_req, mem_we, done, shared}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("mid_reset_no_done", done, 0);
        end
        @(posedge clock);
        #1;
        // After reset cache 0 wins over cache 2.
        run_batch(3'b101, 6'b00_00_01, {5'h07, 5'h00, 5'h08}, 9'b010_000_010, 9'b0);

        // Randomized batches.
        for (int b = 0; b < 40; b++) begin
            logic [2:0]      m;
            logic [5:0]      o;
            logic [3*AW-1:0] a;
            logic [8:0]      h;
            logic [8:0]      d;
            m = 3'($urandom_range(1, 7));
            o = 6'($urandom);
            a = 15'($urandom);
            h = 9'($urandom);
            d = h & 9'($urandom);
            run_batch(m, o, a, h, d);
        end

        repeat (5) @(posedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
